main_memory: RTL and testbench

Behavioural main-memory responder for the direct-access cache: the far end of the cache↔memory line-transfer interface. Accepts one line request at a time from the cache (`cache2mem_*`), waits a programmable access latency, then either returns a 128-bit line or commits a 128-bit line write, signalling completion with a one-cycle `mem2cache_ready` pulse. It serves as the memory model in cache benches and as the template for the later real memory controller.

---
 rtl/main_memory.sv | 109 ++++++++++
 tb/tb_main_memory.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/main_memory.sv
// Behavioural line-granular main memory: accepts one cache line request at a time,
// waits LATENCY cycles, then returns a 128-bit line or commits a line write.
module main_memory #(
    parameter int LINES   = 1024,
    parameter int LATENCY = 4
) (
    input  logic         clk,
    input  logic         r,
    input  logic         cache2mem_valid,
    input  logic         cache2mem_rw,
    input  logic [31:0]  cache2mem_addr,
    input  logic [127:0] cache2mem_data,
    output logic [127:0] mem2cache_data,
    output logic         mem2cache_ready,
    output logic [1:0]   o_dbg_state
);
    localparam int         IDX_W    = $clog2(LINES);
    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [7:0]         r_cnt;
    logic [7:0]         w_cnt_next;
    logic               r_rw;
    logic [IDX_W-1:0]   r_idx;
    logic [127:0]       r_wdata;
    logic               r_ready;
    logic [127:0]       r_data;
    logic               w_accept;
    logic [127:0]       w_line;
    logic               w_unused_addr;

    // Lines never written read back their power-on pattern, so the array itself
    // needs no time-zero contents; only this per-line flag does.
    logic [127:0]       r_mem [LINES];
    logic [LINES-1:0]   r_written = '0;

    function automatic logic [127:0] init_line(input logic [IDX_W-1:0] idx);
        logic [15:0] li;
        li = 16'(idx);
        return {li, 16'd3, li, 16'd2, li, 16'd1, li, 16'd0};
    endfunction

    assign w_accept      = (r_state == IDLE) && cache2mem_valid;
    assign w_line        = r_written[r_idx] ? r_mem[r_idx] : init_line(r_idx);
    assign w_unused_addr = ^{cache2mem_addr[3:0], cache2mem_addr[31:IDX_W+4]};

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (cache2mem_valid) begin
                    w_cnt_next = CNT_LOAD;
                    w_next     = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                w_cnt_next = r_cnt - 8'd1;
                if (r_cnt == 8'd1) w_next = RESP;
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Ready and data are registered one stage behind RESP; an async reset clears
    // the state first, so an in-flight request never reaches the array or ready.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_rw    <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_ready <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_ready <= (r_state == RESP);
            if (w_accept) begin
                r_rw    <= cache2mem_rw;
                r_idx   <= cache2mem_addr[IDX_W+3:4];
                r_wdata <= cache2mem_data;
            end
            if (r_state == RESP) begin
                r_data <= r_rw ? r_wdata : w_line;
            end
        end
    end

    always_ff @(posedge clk) begin
        if ((r_state == RESP) && r_rw) begin
            r_mem[r_idx]     <= r_wdata;
            r_written[r_idx] <= 1'b1;
        end
    end

    assign mem2cache_ready = r_ready;
    assign mem2cache_data  = r_data;
    assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_main_memory.sv
// Self-checking bench for main_memory: a LATENCY=4 instance for the main scenarios and a
// LATENCY=1 instance for the single-cycle-latency back-to-back case.
module tb_main_memory;
  // Handshake: a request is taken on the rising edge where valid is high and the memory is idle;
  // completion is a one-cycle ready pulse with the line on mem2cache_data.
  logic clk = 1'b0;
  logic r;
  always #5 clk = ~clk;

  logic         v4, rw4, rdy4;
  logic [31:0]  a4;
  logic [127:0] d4, q4;
  logic [1:0]   st4;
  logic         v1, rw1, rdy1;
  logic [31:0]  a1;
  logic [127:0] d1, q1;
  logic [1:0]   st1;

  main_memory #(.LINES(1024), .LATENCY(4)) dut (
    .clk(clk), .r(r), .cache2mem_valid(v4), .cache2mem_rw(rw4), .cache2mem_addr(a4),
    .cache2mem_data(d4), .mem2cache_data(q4), .mem2cache_ready(rdy4), .o_dbg_state(st4)
  );

  main_memory #(.LINES(1024), .LATENCY(1)) dut1 (
    .clk(clk), .r(r), .cache2mem_valid(v1), .cache2mem_rw(rw1), .cache2mem_addr(a1),
    .cache2mem_data(d1), .mem2cache_data(q1), .mem2cache_ready(rdy1), .o_dbg_state(st1)
  );

  logic [127:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  function automatic logic [127:0] init_pat(input int line);
    logic [127:0] v;
    for (int w = 0; w < 4; w++) v[w*32 +: 32] = {line[15:0], w[15:0]};
    return v;
  endfunction

  // Drives one request to the LATENCY=4 instance, then scrambles the request fields
  // and records ready for the 8 cycles after acceptance.
  task automatic run_req(input logic rw, input logic [31:0] addr, input logic [127:0] wd,
                         output logic [7:0] mask, output logic [127:0] got);
    @(negedge clk);
    v4 = 1'b1; rw4 = rw; a4 = addr; d4 = wd;
    @(posedge clk);
    mask = '0;
    got = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) begin
        v4 = 1'b0; rw4 = ~rw; a4 = 32'hFFFF_FFF0; d4 = ~wd;
      end
      mask[k] = rdy4;
      if (rdy4) got = q4;
    end
  endtask

  task automatic test_reset;
    r = 1'b0;
    v4 = 1'b0; rw4 = 1'b0; a4 = '0; d4 = '0;
    v1 = 1'b0; rw1 = 1'b0; a1 = '0; d1 = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (rdy4 !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", rdy4); end
    n_checks++;
    if (q4 !== 128'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", q4); end
    n_checks++;
    if (st4 !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", st4); end
    n_checks++;
    if (rdy1 !== 1'b0 || q1 !== 128'h0) begin
      n_fail++; $display("FAIL reset_lat1: got ready %b data %h expected 0/0", rdy1, q1);
    end
    r = 1'b1;
  endtask

  task automatic test_read_after_reset;
    logic [7:0] m;
    logic [127:0] g, e;
    exp_q.push_back(128'h0000_0003_0000_0002_0000_0001_0000_0000);
    run_req(1'b0, 32'h0000_0000, '0, m, g);
    e = exp_q.pop_front();
    n_checks++;
    if (m !== 8'b0001_0000) begin n_fail++; $display("FAIL read0_timing: got %b expected 00010000", m); end
    n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL read0_data: got %h expected %h", g, e); end
    n_checks++;
    if (q4 !== e) begin n_fail++; $display("FAIL read0_hold: got %h expected %h", q4, e); end
  endtask

  task automatic test_alias;
    logic [7:0] m;
    logic [127:0] g, e;
    exp_q.push_back(128'h0004_0003_0004_0002_0004_0001_0004_0000);
    run_req(1'b0, 32'h0000_4040, '0, m, g);
    e = exp_q.pop_front();
    n_checks++;
    if (m !== 8'b0001_0000) begin n_fail++; $display("FAIL alias_timing: got %b expected 00010000", m); end
    n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL alias_data: got %h expected %h", g, e); end
  endtask

  task automatic test_write_read;
    logic [7:0] m;
    logic [127:0] g, e;
    logic [127:0] wd;
    wd = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FFFF_FFFF;
    exp_q.push_back(wd);
    run_req(1'b1, 32'h0000_0080, wd, m, g);
    e = exp_q.pop_front();
    n_checks++;
    if (m !== 8'b0001_0000) begin n_fail++; $display("FAIL write_timing: got %b expected 00010000", m); end
    n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL write_echo: got %h expected %h", g, e); end
    exp_q.push_back(wd);
    run_req(1'b0, 32'h0000_0080, '0, m, g);
    e = exp_q.pop_front();
    n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL write_readback: got %h expected %h", g, e); end
    exp_q.push_back(wd);
    run_req(1'b0, 32'hABC0_0085, '0, m, g);
    e = exp_q.pop_front();
    n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL write_alias_readback: got %h expected %h", g, e); end
    exp_q.push_back(init_pat(9));
    run_req(1'b0, 32'h0000_0090, '0, m, g);
    e = exp_q.pop_front();
    n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL line9_untouched: got %h expected %h", g, e); end
  endtask

  task automatic test_busy_ignore;
    logic [11:0] m;
    logic [127:0] e;
    m = '0;
    exp_q.push_back(init_pat(0));
    @(negedge clk);
    v4 = 1'b1; rw4 = 1'b0; a4 = 32'h0000_0000; d4 = '0;
    @(posedge clk);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 1) begin a4 = 32'h0000_0010; exp_q.push_back(init_pat(1)); end
      m[k] = rdy4;
      if (rdy4) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL busy_extra_response: got %h expected none", q4);
        end else begin
          e = exp_q.pop_front();
          if (q4 !== e) begin n_fail++; $display("FAIL busy_data: got %h expected %h", q4, e); end
        end
      end
      if (k == 9) v4 = 1'b0;
    end
    n_checks++;
    if (m !== 12'h210) begin n_fail++; $display("FAIL busy_timing: got %b expected 001000010000", m); end
  endtask

  task automatic test_reset_mid_write;
    logic [7:0] m;
    logic [127:0] g, e;
    int cnt;
    @(negedge clk);
    v4 = 1'b1; rw4 = 1'b1; a4 = 32'h0000_0020; d4 = 128'hCAFE_F00D_1111_2222_3333_4444_5555_6666;
    @(posedge clk);
    @(negedge clk);
    v4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 r = 1'b0;
    #1;
    n_checks++;
    if (rdy4 !== 1'b0) begin n_fail++; $display("FAIL midreset_ready: got %b expected 0", rdy4); end
    n_checks++;
    if (q4 !== 128'h0) begin n_fail++; $display("FAIL midreset_data: got %h expected 0", q4); end
    n_checks++;
    if (st4 !== 2'd0) begin n_fail++; $display("FAIL midreset_state: got %0d expected 0", st4); end
    repeat (2) @(negedge clk);
    r = 1'b1;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rdy4) cnt++;
    end
    n_checks++;
    if (cnt != 0) begin n_fail++; $display("FAIL midreset_no_pulse: got %0d pulses expected 0", cnt); end
    exp_q.push_back(128'h0002_0003_0002_0002_0002_0001_0002_0000);
    run_req(1'b0, 32'h0000_0020, '0, m, g);
    e = exp_q.pop_front();
    n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL midreset_line2: got %h expected %h", g, e); end
  endtask

  task automatic test_lat1_back_to_back;
    logic [9:0] m;
    logic [127:0] e;
    m = '0;
    exp_q.push_back(init_pat(3));
    @(negedge clk);
    v1 = 1'b1; rw1 = 1'b0; a1 = 32'h0000_0030; d1 = '0;
    @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) begin a1 = 32'h0000_0050; exp_q.push_back(init_pat(5)); end
      if (k == 2) begin a1 = 32'h0000_0070; exp_q.push_back(init_pat(7)); end
      if (k == 4) begin a1 = 32'h0001_0090; exp_q.push_back(init_pat(9)); end
      if (k == 6) v1 = 1'b0;
      m[k] = rdy1;
      if (rdy1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL lat1_extra_response: got %h expected none", q1);
        end else begin
          e = exp_q.pop_front();
          if (q1 !== e) begin n_fail++; $display("FAIL lat1_data: got %h expected %h", q1, e); end
        end
      end
    end
    n_checks++;
    if (m !== 10'b00_1010_1010) begin
      n_fail++; $display("FAIL lat1_timing: got %b expected 0010101010", m);
    end
  endtask

  initial begin
    test_reset();
    test_read_after_reset();
    test_alias();
    test_write_read();
    test_busy_ignore();
    test_reset_mid_write();
    test_lat1_back_to_back();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
